sad_best_match: RTL and testbench

Motion-search selection stage that sits directly downstream of the 8-pixel SAD accumulator. It consumes one accumulated 16-bit block SAD per candidate position. It tracks the minimum SAD and the index of the candidate that produced it. At the end of the search window it presents the winning pair through a valid/ready handshake.

---
 rtl/sad_best_match_if.sv | 23 ++
 rtl/sad_best_match.sv | 100 ++++++++++
 tb/tb_sad_best_match.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sad_best_match_if.sv
// Candidate-in / result-out handshake bundle for the SAD best-match selector.
interface sad_best_match_if #(
  parameter int SAD_W = 16,
  parameter int IDX_W = 6
);
  logic             in_valid;
  logic [SAD_W-1:0] in_sad;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [SAD_W-1:0] best_sad;
  logic [IDX_W-1:0] best_idx;

  modport master (
    output in_valid, in_sad, out_ready,
    input  in_ready, out_valid, best_sad, best_idx
  );

  modport slave (
    input  in_valid, in_sad, out_ready,
    output in_ready, out_valid, best_sad, best_idx
  );
endinterface

// File: rtl/sad_best_match.sv
// Tracks the minimum block SAD and its arrival index over a search window.
// Optional early termination on a threshold hit: define SAD_EARLY_TERM_EN.
module sad_best_match #(
  parameter int SAD_W    = 16,
  parameter int IDX_W    = 6,
  parameter int NUM_CAND = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SAD_EARLY_TERM_EN
  input  logic [SAD_W-1:0] thresh,
`endif
  sad_best_match_if.slave  bus,
  output logic [IDX_W:0]   cand_cnt,
  output logic             busy,
  output logic             early_term
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  localparam logic [IDX_W:0]   LAST_CNT = (IDX_W+1)'(NUM_CAND - 1);
  localparam logic [SAD_W-1:0] SAD_MAX  = '1;

  state_t           state, state_nxt;
  logic             xfer;
  logic             hit;
  logic             win_done;
  logic [SAD_W-1:0] best_sad_r;
  logic [IDX_W-1:0] best_idx_r;

  // Strict compare keeps the earliest index on ties.
  function automatic logic is_better(input logic [SAD_W-1:0] cand,
                                     input logic [SAD_W-1:0] best);
    return cand < best;
  endfunction

  assign xfer = bus.in_valid && (state == SEARCH);
`ifdef SAD_EARLY_TERM_EN
  assign hit = bus.in_sad <= thresh;
`else
  assign hit = 1'b0;
`endif
  assign win_done = xfer && ((cand_cnt == LAST_CNT) || hit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)         state_nxt = SEARCH;
      SEARCH:  if (win_done)      state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Running minimum: one comparator and one mux per accepted candidate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_sad_r <= SAD_MAX;
      best_idx_r <= '0;
      cand_cnt   <= '0;
    end else if (state == IDLE && start) begin
      best_sad_r <= SAD_MAX;
      best_idx_r <= '0;
      cand_cnt   <= '0;
    end else if (xfer) begin
      cand_cnt <= cand_cnt + 1'b1;
      if (is_better(bus.in_sad, best_sad_r)) begin
        best_sad_r <= bus.in_sad;
        best_idx_r <= cand_cnt[IDX_W-1:0];
      end
    end
  end

`ifdef SAD_EARLY_TERM_EN
  logic early_term_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      early_term_r <= 1'b0;
    else if (state == IDLE && start) early_term_r <= 1'b0;
    else if (win_done)               early_term_r <= hit;
  end

  assign early_term = early_term_r;
`else
  assign early_term = 1'b0;
`endif

  assign bus.in_ready  = (state == SEARCH);
  assign bus.out_valid = (state == DONE);
  assign bus.best_sad  = best_sad_r;
  assign bus.best_idx  = best_idx_r;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_sad_best_match.sv
// Randomized and directed bench for sad_best_match against a window-list reference model.
module tb_sad_best_match;
  localparam int SAD_W = 16;
  localparam int IDX_W = 6;
  localparam int NC    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
`ifdef SAD_EARLY_TERM_EN
  logic [SAD_W-1:0] thresh = '0;
`endif
  logic [IDX_W:0]   cand_cnt;
  logic             busy;
  logic             early_term;

  sad_best_match_if #(.SAD_W(SAD_W), .IDX_W(IDX_W)) bus ();

  sad_best_match #(.SAD_W(SAD_W), .IDX_W(IDX_W), .NUM_CAND(NC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
`ifdef SAD_EARLY_TERM_EN
    .thresh     (thresh),
`endif
    .bus        (bus),
    .cand_cnt   (cand_cnt),
    .busy       (busy),
    .early_term (early_term)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 searching, 2 result held; the window is the list of accepted SADs.
  int          m_phase = 0;
  int          m_n     = 0;
  bit          m_et    = 1'b0;
  logic [15:0] m_sad [64];

  initial begin
    bit hit;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_phase = 0; m_n = 0; m_et = 1'b0;
      end else begin
        case (m_phase)
          0: if (start) begin m_phase = 1; m_n = 0; m_et = 1'b0; end
          1: if (bus.in_valid) begin
               hit = 1'b0;
`ifdef SAD_EARLY_TERM_EN
               hit = (bus.in_sad <= thresh);
`endif
               m_sad[m_n] = bus.in_sad;
               m_n++;
               if (m_n == NC || hit) begin m_phase = 2; m_et = hit; end
             end
          default: if (bus.out_ready) m_phase = 0;
        endcase
      end
    end
  end

  int checks   = 0;
  int failures = 0;
  int lit_id   = 0;
  int lit_done = 0;
  bit finished    = 1'b0;
  bit timeout_hit = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: model every cycle, plus hand-computed literals when the driver requests them.
  initial begin
    logic [15:0] eb;
    int          ei;
    forever begin
      @(negedge clk);
      eb = 16'hFFFF; ei = 0;
      for (int i = 0; i < m_n; i++)
        if (m_sad[i] < eb) begin eb = m_sad[i]; ei = i; end
      chk("in_ready",   32'(bus.in_ready),  32'(m_phase == 1));
      chk("out_valid",  32'(bus.out_valid), 32'(m_phase == 2));
      chk("busy",       32'(busy),          32'(m_phase != 0));
      chk("cand_cnt",   32'(cand_cnt),      32'(m_n));
      chk("best_sad",   32'(bus.best_sad),  32'(eb));
      chk("best_idx",   32'(bus.best_idx),  32'(ei));
      chk("early_term", 32'(early_term),    32'(m_et));
      if (lit_id != lit_done) begin
        case (lit_id)
          1: begin
               chk("rst_sad", 32'(bus.best_sad), 32'hFFFF);
               chk("rst_idx", 32'(bus.best_idx), 0);
               chk("rst_cnt", 32'(cand_cnt), 0);
               chk("rst_flags", {28'd0, bus.in_ready, bus.out_valid, busy, early_term}, 0);
             end
          2: begin
               chk("full_valid", 32'(bus.out_valid), 1);
               chk("full_sad", 32'(bus.best_sad), 120);
               chk("full_idx", 32'(bus.best_idx), 1);
               chk("full_cnt", 32'(cand_cnt), 4);
             end
          3: begin
               chk("ign_busy", 32'(busy), 0);
               chk("ign_cnt", 32'(cand_cnt), 4);
               chk("ign_sad", 32'(bus.best_sad), 120);
             end
          4: begin
               chk("stall_valid", 32'(bus.out_valid), 1);
               chk("stall_sad", 32'(bus.best_sad), 50);
               chk("stall_idx", 32'(bus.best_idx), 0);
               chk("stall_cnt", 32'(cand_cnt), 4);
             end
          5: begin
               chk("rel_valid", 32'(bus.out_valid), 0);
               chk("rel_busy", 32'(busy), 0);
               chk("rel_sad", 32'(bus.best_sad), 50);
             end
          6: begin
               chk("abort_sad", 32'(bus.best_sad), 32'hFFFF);
               chk("abort_cnt", 32'(cand_cnt), 0);
               chk("abort_busy", 32'(busy), 0);
             end
          7: begin
               chk("post_sad", 32'(bus.best_sad), 5);
               chk("post_idx", 32'(bus.best_idx), 2);
               chk("post_cnt", 32'(cand_cnt), 4);
               chk("post_et", 32'(early_term), 0);
             end
          8: begin
               chk("et_valid", 32'(bus.out_valid), 1);
               chk("et_sad", 32'(bus.best_sad), 90);
               chk("et_idx", 32'(bus.best_idx), 1);
               chk("et_cnt", 32'(cand_cnt), 2);
               chk("et_flag", 32'(early_term), 1);
             end
          default: ;
        endcase
        lit_done = lit_id;
      end
      if (finished) begin
        chk("drain_timeout", 32'(timeout_hit), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] s, input bit gap);
    if (gap) begin
      bus.in_valid = 1'b0; bus.in_sad = 16'($urandom); tick();
    end
    bus.in_valid = 1'b1; bus.in_sad = s; tick();
  endtask

  function automatic logic [15:0] rnd_sad();
    case ($urandom_range(0, 5))
      0:       return 16'hFFFF;
      1:       return 16'd50;
      2:       return 16'($urandom_range(0, 3));
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    bus.in_valid = 1'b0; bus.in_sad = '0; bus.out_ready = 1'b0;
    #2 reset = 1'b0;
    tick(); lit_id = 1;
    tick(); reset = 1'b1;
    tick();

    // Full window
    start = 1'b1; tick(); start = 1'b0;
    feed(16'd300, 0); feed(16'd120, 0); feed(16'd450, 0); feed(16'd200, 0);
    bus.in_valid = 1'b0; lit_id = 2;
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

    // in_valid in IDLE is not a transfer
    bus.in_valid = 1'b1; bus.in_sad = 16'd7; tick(); tick();
    bus.in_valid = 1'b0; lit_id = 3;

    // Ties, gaps, start in SEARCH and DONE, stalled result
    start = 1'b1; tick();
    feed(16'd50, 0); start = 1'b0;
    feed(16'd50, 1); feed(16'd80, 0); feed(16'd50, 1);
    start = 1'b1; bus.in_valid = 1'b1; bus.in_sad = 16'd1;
    tick(); tick(); tick();
    lit_id = 4; start = 1'b0; bus.in_valid = 1'b0;
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0; lit_id = 5;
    tick();

    // Reset mid-window, then a clean window
    start = 1'b1; tick(); start = 1'b0;
    feed(16'd3, 0); feed(16'd4, 0);
    bus.in_valid = 1'b0;
    #1 reset = 1'b0; lit_id = 6;
    tick(); reset = 1'b1; tick();
    start = 1'b1; tick(); start = 1'b0;
    feed(16'd10, 0); feed(16'd20, 0); feed(16'd5, 0); feed(16'd30, 0);
    bus.in_valid = 1'b0; lit_id = 7;
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;

`ifdef SAD_EARLY_TERM_EN
    thresh = 16'd100;
    start = 1'b1; tick(); start = 1'b0;
    feed(16'd400, 0); feed(16'd90, 0);
    bus.in_valid = 1'b0; lit_id = 8;
    bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
`endif

    // Randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      start         = ($urandom_range(0, 3) == 0);
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_sad    = rnd_sad();
      bus.out_ready = 1'($urandom_range(0, 1));
`ifdef SAD_EARLY_TERM_EN
      thresh = 16'($urandom_range(0, 40));
`endif
      if ($urandom_range(0, 99) == 0) begin
        #1 reset = 1'b0;
        tick(); reset = 1'b1;
      end else begin
        tick();
      end
    end

    // Drain: finish any open window and release the result
    start = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    begin
      int n;
      n = 0;
      tick();
      while (busy && n < 20) begin tick(); n++; end
      if (busy) timeout_hit = 1'b1;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    finished = 1'b1;
    repeat (5) tick();
    $display("FAIL summary_not_reached actual=0 required=1");
    $fatal(1);
  end
endmodule
